// File: rtl/dsp_xintf_bram_bridge.sv
// XINTF-to-BRAM bridge: synchronised XINTF strobes drive an access FSM that issues
// single-cycle command-RAM writes and status-RAM reads with a registered read-back path.
module dsp_xintf_bram_bridge #(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_dsp_ce,
  input  logic                  i_dsp_we,
  input  logic                  i_dsp_rd,
  input  logic [ADDR_WIDTH-1:0] i_dsp_xa,
  input  logic [DATA_WIDTH-1:0] i_dsp_xd,
  output logic [DATA_WIDTH-1:0] o_dsp_xd,
  output logic                  o_dsp_xd_oe,
  output logic [ADDR_WIDTH-1:0] o_wr_ram_addr,
  output logic [DATA_WIDTH-1:0] o_wr_ram_din,
  output logic                  o_wr_ram_en,
  output logic                  o_wr_ram_we,
  output logic [ADDR_WIDTH-1:0] o_rd_ram_addr,
  output logic                  o_rd_ram_en,
  input  logic [DATA_WIDTH-1:0] i_rd_ram_dout,
  output logic                  o_wr_done,
  output logic                  o_rd_done,
  output logic                  o_bus_err,
  output logic [CNT_WIDTH-1:0]  o_wr_cnt,
  output logic [CNT_WIDTH-1:0]  o_rd_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_ACT    = 3'd1,
    ST_WR_COMMIT = 3'd2,
    ST_RD_REQ    = 3'd3,
    ST_RD_WAIT   = 3'd4,
    ST_RD_DRIVE  = 3'd5,
    ST_ERR       = 3'd6,
    ST_ARM       = 3'd7
  } state_t;

  logic [SYNC_STAGES-1:0] ce_sync_r;
  logic [SYNC_STAGES-1:0] we_sync_r;
  logic [SYNC_STAGES-1:0] rd_sync_r;
  logic                   wr_act_s;
  logic                   rd_act_s;
  logic [ADDR_WIDTH-1:0]  addr_r;
  logic [DATA_WIDTH-1:0]  data_r;
  logic [ADDR_WIDTH-1:0]  hold_addr_r;
  logic [DATA_WIDTH-1:0]  hold_data_r;
  logic [1:0]             wait_cnt_r;
  logic                   wait_last_s;
  state_t                 state_r;
  state_t                 next_state_s;

  // Strobe synchronisers; cleared low so an access in flight at reset looks active until seen released.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ce_sync_r <= '0;
      we_sync_r <= '0;
      rd_sync_r <= '0;
    end else begin
      ce_sync_r <= {ce_sync_r[SYNC_STAGES-2:0], i_dsp_ce};
      we_sync_r <= {we_sync_r[SYNC_STAGES-2:0], i_dsp_we};
      rd_sync_r <= {rd_sync_r[SYNC_STAGES-2:0], i_dsp_rd};
    end
  end

  assign wr_act_s    = ~ce_sync_r[SYNC_STAGES-1] & ~we_sync_r[SYNC_STAGES-1];
  assign rd_act_s    = ~ce_sync_r[SYNC_STAGES-1] & ~rd_sync_r[SYNC_STAGES-1];
  assign wait_last_s = (wait_cnt_r == 2'(RD_LATENCY - 1));

  // Next-state decode for the access sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (wr_act_s && rd_act_s) next_state_s = ST_ERR;
        else if (wr_act_s)        next_state_s = ST_WR_ACT;
        else if (rd_act_s)        next_state_s = ST_RD_REQ;
        else                      next_state_s = ST_IDLE;
      end
      ST_WR_ACT: begin
        if (rd_act_s)       next_state_s = ST_ERR;
        else if (!wr_act_s) next_state_s = ST_WR_COMMIT;
        else                next_state_s = ST_WR_ACT;
      end
      ST_WR_COMMIT: next_state_s = ST_IDLE;
      ST_RD_REQ:    next_state_s = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (wait_last_s) next_state_s = ST_RD_DRIVE;
        else             next_state_s = ST_RD_WAIT;
      end
      ST_RD_DRIVE: begin
        if (wr_act_s)       next_state_s = ST_ERR;
        else if (!rd_act_s) next_state_s = ST_IDLE;
        else                next_state_s = ST_RD_DRIVE;
      end
      ST_ERR: next_state_s = ST_ARM;
      ST_ARM: begin
        if (!wr_act_s && !rd_act_s) next_state_s = ST_IDLE;
        else                        next_state_s = ST_ARM;
      end
      default: next_state_s = ST_ARM;
    endcase
  end

  // State register, per-cycle bus sampling and the write holding register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= ST_ARM;
      addr_r      <= '0;
      data_r      <= '0;
      hold_addr_r <= '0;
      hold_data_r <= '0;
      wait_cnt_r  <= 2'd0;
    end else begin
      state_r <= next_state_s;
      addr_r  <= i_dsp_xa;
      data_r  <= i_dsp_xd;
      if (next_state_s == ST_WR_ACT) begin
        hold_addr_r <= addr_r;
        hold_data_r <= data_r;
      end
      wait_cnt_r <= (state_r == ST_RD_WAIT) ? wait_cnt_r + 2'd1 : 2'd0;
    end
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dsp_xd      <= '0;
      o_dsp_xd_oe   <= 1'b0;
      o_wr_ram_addr <= '0;
      o_wr_ram_din  <= '0;
      o_wr_ram_en   <= 1'b0;
      o_wr_ram_we   <= 1'b0;
      o_rd_ram_addr <= '0;
      o_rd_ram_en   <= 1'b0;
      o_wr_done     <= 1'b0;
      o_rd_done     <= 1'b0;
      o_bus_err     <= 1'b0;
      o_wr_cnt      <= '0;
      o_rd_cnt      <= '0;
    end else begin
      o_wr_ram_en   <= (next_state_s == ST_WR_COMMIT);
      o_wr_ram_we   <= (next_state_s == ST_WR_COMMIT);
      o_wr_done     <= (next_state_s == ST_WR_COMMIT);
      o_wr_ram_addr <= (next_state_s == ST_WR_COMMIT) ? hold_addr_r : '0;
      o_wr_ram_din  <= (next_state_s == ST_WR_COMMIT) ? hold_data_r : '0;
      o_rd_ram_en   <= (next_state_s == ST_RD_REQ);
      o_rd_ram_addr <= (next_state_s == ST_RD_REQ) ? addr_r : '0;
      o_dsp_xd_oe   <= (next_state_s == ST_RD_DRIVE);
      o_bus_err     <= (next_state_s == ST_ERR);
      o_rd_done     <= (state_r == ST_RD_DRIVE) && (next_state_s == ST_IDLE);
      if (state_r == ST_RD_WAIT && wait_last_s) begin
        o_dsp_xd <= i_rd_ram_dout;
      end
      if (next_state_s == ST_WR_COMMIT) begin
        o_wr_cnt <= o_wr_cnt + CNT_WIDTH'(1'b1);
      end
      if (state_r == ST_RD_DRIVE && next_state_s == ST_IDLE) begin
        o_rd_cnt <= o_rd_cnt + CNT_WIDTH'(1'b1);
      end
    end
  end

endmodule

// File: tb/tb_dsp_xintf_bram_bridge.sv
// Scoreboard bench for dsp_xintf_bram_bridge: one default instance and one with
// RD_LATENCY=2 / CNT_WIDTH=4 share the XINTF strobes; each has its own status RAM model.
module tb_dsp_xintf_bram_bridge;

  typedef struct packed {
    logic [8:0]  addr;
    logic [15:0] data;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1, we = 1'b1, rd = 1'b1;
  logic [8:0]  xa = 9'd0;
  logic [15:0] xd = 16'd0;

  logic [15:0] xd0, din0, dout0, xd1, din1, dout1, p1;
  logic [8:0]  wa0, ra0, wa1, ra1;
  logic        oe0, wen0, wwe0, ren0, wdn0, rdn0, err0;
  logic        oe1, wen1, wwe1, ren1, wdn1, rdn1, err1;
  logic [15:0] wcnt0, rcnt0;
  logic [3:0]  wcnt1, rcnt1;

  logic [15:0] mem [0:511];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  acc_t        wr_q[$];
  acc_t        rd_q[$];
  logic [15:0] rd1_q[$];
  acc_t        obs_wr_q[$];
  logic [8:0]  obs_rd_addr_q[$];
  logic [15:0] obs_rd_data_q[$];
  logic [15:0] obs_rd1_q[$];

  int wr_en_cyc, oe0_rise_cyc, oe0_fall_cyc, oe1_rise_cyc;
  int wr_en_cnt = 0, wr_en1_cnt = 0, err_cnt = 0, wdn_cnt = 0, rdn_cnt = 0;
  int oe_rise_cnt = 0, bad_we = 0, unstable = 0;
  logic        prev_oe0 = 1'b0, prev_oe1 = 1'b0;
  logic [15:0] prev_xd0 = 16'd0;

  wire [88:0] outs0 = {xd0, oe0, wa0, din0, wen0, wwe0, ra0, ren0, wdn0, rdn0, err0, wcnt0, rcnt0};

  dsp_xintf_bram_bridge dut0 (
    .i_clk(clk), .i_rst(rst), .i_dsp_ce(ce), .i_dsp_we(we), .i_dsp_rd(rd),
    .i_dsp_xa(xa), .i_dsp_xd(xd), .o_dsp_xd(xd0), .o_dsp_xd_oe(oe0),
    .o_wr_ram_addr(wa0), .o_wr_ram_din(din0), .o_wr_ram_en(wen0), .o_wr_ram_we(wwe0),
    .o_rd_ram_addr(ra0), .o_rd_ram_en(ren0), .i_rd_ram_dout(dout0),
    .o_wr_done(wdn0), .o_rd_done(rdn0), .o_bus_err(err0), .o_wr_cnt(wcnt0), .o_rd_cnt(rcnt0)
  );

  dsp_xintf_bram_bridge #(.RD_LATENCY(2), .CNT_WIDTH(4)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_dsp_ce(ce), .i_dsp_we(we), .i_dsp_rd(rd),
    .i_dsp_xa(xa), .i_dsp_xd(xd), .o_dsp_xd(xd1), .o_dsp_xd_oe(oe1),
    .o_wr_ram_addr(wa1), .o_wr_ram_din(din1), .o_wr_ram_en(wen1), .o_wr_ram_we(wwe1),
    .o_rd_ram_addr(ra1), .o_rd_ram_en(ren1), .i_rd_ram_dout(dout1),
    .o_wr_done(wdn1), .o_rd_done(rdn1), .o_bus_err(err1), .o_wr_cnt(wcnt1), .o_rd_cnt(rcnt1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Status RAM models: latency 1 for dut0, latency 2 for dut1.
  always @(posedge clk) begin
    if (ren0) dout0 <= mem[ra0];
    if (ren1) p1 <= mem[ra1];
    dout1 <= p1;
  end

  // Output monitor: records what the DUTs produce, sampled on the falling edge.
  always @(negedge clk) begin
    prev_oe0 <= oe0;
    prev_oe1 <= oe1;
    prev_xd0 <= xd0;
    if (wen0) begin
      obs_wr_q.push_back({wa0, din0});
      wr_en_cyc <= cyc;
      wr_en_cnt <= wr_en_cnt + 1;
      if (!wwe0) bad_we <= bad_we + 1;
    end
    if (wen1) wr_en1_cnt <= wr_en1_cnt + 1;
    if (ren0) obs_rd_addr_q.push_back(ra0);
    if (oe0 && !prev_oe0) begin
      obs_rd_data_q.push_back(xd0);
      oe0_rise_cyc <= cyc;
      oe_rise_cnt  <= oe_rise_cnt + 1;
    end
    if (oe0 && prev_oe0 && xd0 !== prev_xd0) unstable <= unstable + 1;
    if (!oe0 && prev_oe0) oe0_fall_cyc <= cyc;
    if (oe1 && !prev_oe1) begin
      obs_rd1_q.push_back(xd1);
      oe1_rise_cyc <= cyc;
    end
    if (err0) err_cnt <= err_cnt + 1;
    if (wdn0) wdn_cnt <= wdn_cnt + 1;
    if (rdn0) rdn_cnt <= rdn_cnt + 1;
  end

  task automatic do_write(input logic [8:0] a, input logic [15:0] d, input int len);
    acc_t e, o;
    int   t_rise;
    @(posedge clk); #1;
    xa = a; xd = d; ce = 1'b0; we = 1'b0;
    wr_q.push_back({a, d});
    repeat (len) @(posedge clk);
    #1; we = 1'b1; ce = 1'b1; t_rise = cyc;
    repeat (6) @(posedge clk);
    #1;
    e = wr_q.pop_front();
    n_checks++;
    if (obs_wr_q.size() != 1) begin
      n_fail++;
      $display("FAIL wr_commit_count got %0d want 1 (addr %h)", obs_wr_q.size(), a);
      obs_wr_q.delete();
    end else begin
      o = obs_wr_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wr_addr_data got %h want %h", o, e);
      end
      n_checks++;
      if (wr_en_cyc - t_rise != 3) begin
        n_fail++;
        $display("FAIL wr_latency got %0d want 3", wr_en_cyc - t_rise);
      end
    end
  endtask

  task automatic do_read(input logic [8:0] a, input int len);
    acc_t        e;
    logic [15:0] e1;
    int          t_fall, t_rise;
    @(posedge clk); #1;
    xa = a; ce = 1'b0; rd = 1'b0; t_fall = cyc;
    rd_q.push_back({a, mem[a]});
    rd1_q.push_back(mem[a]);
    repeat (len) @(posedge clk);
    #1; rd = 1'b1; ce = 1'b1; t_rise = cyc;
    repeat (6) @(posedge clk);
    #1;
    e  = rd_q.pop_front();
    e1 = rd1_q.pop_front();
    n_checks++;
    if (obs_rd_addr_q.size() != 1 || obs_rd_addr_q[0] !== e.addr) begin
      n_fail++;
      $display("FAIL rd_ram_addr got %0d entries (first %h) want 1 entry %h",
               obs_rd_addr_q.size(), (obs_rd_addr_q.size() > 0) ? obs_rd_addr_q[0] : 9'h0, e.addr);
    end
    n_checks++;
    if (obs_rd_data_q.size() != 1 || obs_rd_data_q[0] !== e.data) begin
      n_fail++;
      $display("FAIL rd_data got %0d entries (first %h) want %h",
               obs_rd_data_q.size(), (obs_rd_data_q.size() > 0) ? obs_rd_data_q[0] : 16'h0, e.data);
    end
    n_checks++;
    if (obs_rd1_q.size() != 1 || obs_rd1_q[0] !== e1) begin
      n_fail++;
      $display("FAIL rd_data_lat2 got %0d entries (first %h) want %h",
               obs_rd1_q.size(), (obs_rd1_q.size() > 0) ? obs_rd1_q[0] : 16'h0, e1);
    end
    n_checks++;
    if (oe0_rise_cyc - t_fall != 5) begin
      n_fail++;
      $display("FAIL oe_rise_lat1 got %0d want 5", oe0_rise_cyc - t_fall);
    end
    n_checks++;
    if (oe1_rise_cyc - t_fall != 6) begin
      n_fail++;
      $display("FAIL oe_rise_lat2 got %0d want 6", oe1_rise_cyc - t_fall);
    end
    n_checks++;
    if (oe0_fall_cyc - t_rise != 3) begin
      n_fail++;
      $display("FAIL oe_fall got %0d want 3", oe0_fall_cyc - t_rise);
    end
    obs_rd_addr_q.delete();
    obs_rd_data_q.delete();
    obs_rd1_q.delete();
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    repeat (5) @(posedge clk);
    obs_wr_q.delete();
    obs_rd_addr_q.delete();
    obs_rd_data_q.delete();
    obs_rd1_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (outs0 !== 89'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want 0", outs0);
    end
    n_checks++;
    if ({oe1, wen1, ren1, wcnt1, rcnt1} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_lat2 got %h want 0", {oe1, wen1, ren1, wcnt1, rcnt1});
    end
    #1; rst = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_write();
    int d0;
    d0 = wdn_cnt;
    do_write(9'h05A, 16'hBEEF, 8);
    n_checks++;
    if (wcnt0 !== 16'd1 || wdn_cnt - d0 != 1 || bad_we != 0) begin
      n_fail++;
      $display("FAIL write_count got cnt=%0d done=%0d bad_we=%0d want 1 1 0", wcnt0, wdn_cnt - d0, bad_we);
    end
  endtask

  task automatic test_read();
    int d0;
    d0 = rdn_cnt;
    do_read(9'h100, 10);
    n_checks++;
    if (rcnt0 !== 16'd1 || rcnt1 !== 4'd1 || rdn_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL read_count got %0d/%0d done=%0d want 1/1 1", rcnt0, rcnt1, rdn_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    int          w0, r0, e0, wd0, rd0;
    logic [15:0] w_base, r_base;
    w0 = wr_en_cnt; e0 = err_cnt; wd0 = wdn_cnt; rd0 = rdn_cnt;
    w_base = wcnt0; r_base = rcnt0;
    for (int i = 0; i < 8; i++) begin
      do_write(9'(i * 7 + 1), 16'($urandom), 5);
      do_read(9'(i * 3 + 9'h080), 9);
    end
    n_checks++;
    if (wr_en_cnt - w0 != 8 || wdn_cnt - wd0 != 8 || rdn_cnt - rd0 != 8) begin
      n_fail++;
      $display("FAIL b2b_events got wr_en=%0d wr_done=%0d rd_done=%0d want 8 8 8",
               wr_en_cnt - w0, wdn_cnt - wd0, rdn_cnt - rd0);
    end
    n_checks++;
    if (err_cnt != e0) begin
      n_fail++;
      $display("FAIL b2b_bus_err got %0d want 0", err_cnt - e0);
    end
    n_checks++;
    if (wcnt0 !== w_base + 16'd8 || rcnt0 !== r_base + 16'd8) begin
      n_fail++;
      $display("FAIL b2b_counters got %0d/%0d want %0d/%0d", wcnt0, rcnt0, w_base + 16'd8, r_base + 16'd8);
    end
    n_checks++;
    if (unstable != 0) begin
      n_fail++;
      $display("FAIL xd_hold got %0d changes while oe want 0", unstable);
    end
  endtask

  task automatic test_bus_error();
    int          e0, w0;
    logic [15:0] c0;
    e0 = err_cnt; w0 = wr_en_cnt; c0 = wcnt0;
    @(posedge clk); #1;
    xa = 9'h033; xd = 16'hDEAD; ce = 1'b0; we = 1'b0;
    repeat (6) @(posedge clk);
    #1; rd = 1'b0;
    repeat (6) @(posedge clk);
    #1; we = 1'b1; rd = 1'b1; ce = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (err_cnt - e0 != 1) begin
      n_fail++;
      $display("FAIL bus_err_pulse got %0d cycles want 1", err_cnt - e0);
    end
    n_checks++;
    if (wr_en_cnt != w0 || wcnt0 !== c0 || obs_wr_q.size() != 0 || obs_rd_addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL bus_err_no_access got wr_en=%0d cnt=%0d rd_en=%0d want 0 %0d 0",
               wr_en_cnt - w0, wcnt0, obs_rd_addr_q.size(), c0);
    end
    obs_wr_q.delete();
    obs_rd_addr_q.delete();
    do_write(9'h044, 16'hCAFE, 8);
    n_checks++;
    if (wcnt0 !== c0 + 16'd1) begin
      n_fail++;
      $display("FAIL bus_err_resume got %0d want %0d", wcnt0, c0 + 16'd1);
    end
  endtask

  task automatic test_reset_mid_read();
    int d0, o0;
    @(posedge clk); #1;
    xa = 9'h0A0; ce = 1'b0; rd = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (oe0 !== 1'b1 || xd0 !== mem[9'h0A0]) begin
      n_fail++;
      $display("FAIL pre_reset_drive got oe=%b xd=%h want 1 %h", oe0, xd0, mem[9'h0A0]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outs0 !== 89'd0 || oe1 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_read_reset got %h oe1=%b want 0", outs0, oe1);
    end
    obs_rd_addr_q.delete();
    obs_rd_data_q.delete();
    obs_rd1_q.delete();
    d0 = rdn_cnt; o0 = oe_rise_cnt;
    repeat (4) @(posedge clk);
    #1; rd = 1'b1; ce = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (rdn_cnt != d0 || oe_rise_cnt != o0 || obs_rd_addr_q.size() != 0 || rcnt0 !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_read_no_access got done=%0d oe=%0d rd_en=%0d cnt=%0d want 0 0 0 0",
               rdn_cnt - d0, oe_rise_cnt - o0, obs_rd_addr_q.size(), rcnt0);
    end
    do_read(9'h100, 10);
    n_checks++;
    if (rcnt0 !== 16'd1) begin
      n_fail++;
      $display("FAIL post_reset_read_count got %0d want 1", rcnt0);
    end
  endtask

  task automatic test_counter_wrap();
    int w1;
    pulse_reset();
    w1 = wr_en1_cnt;
    for (int i = 0; i < 17; i++) begin
      do_write(9'(9'h1F0 + i), 16'(16'hA000 + i), 4);
    end
    n_checks++;
    if (wcnt0 !== 16'd17) begin
      n_fail++;
      $display("FAIL wr_cnt_17 got %0d want 17", wcnt0);
    end
    n_checks++;
    if (wcnt1 !== 4'd1 || wr_en1_cnt - w1 != 17) begin
      n_fail++;
      $display("FAIL wr_cnt_wrap got %0d (commits %0d) want 1 (17)", wcnt1, wr_en1_cnt - w1);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
    mem[9'h100] = 16'h1234;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_bus_error();
    test_reset_mid_read();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
